// File: rtl/sdram_port_ctrl_if.sv
// sdram_port_ctrl_if: user FIFO ports and SDRAM controller handshake.
// master = the port controller, slave = user logic plus SDRAM controller.
interface sdram_port_ctrl_if;
  logic        wr_fifo_wr_en;
  logic [31:0] wr_fifo_wr_data;
  logic        wr_fifo_full;
  logic        rd_fifo_rd_en;
  logic [31:0] rd_fifo_rd_data;
  logic        rd_fifo_empty;
  logic        rd_valid;
  logic        sdram_wr_req;
  logic [20:0] sdram_wr_addr;
  logic [8:0]  wr_burst_len;
  logic [31:0] sdram_data_in;
  logic        sdram_wr_ack;
  logic        sdram_rd_req;
  logic [20:0] sdram_rd_addr;
  logic [8:0]  rd_burst_len;
  logic [31:0] sdram_data_out;
  logic        sdram_rd_ack;

  modport master (
    input  wr_fifo_wr_en, wr_fifo_wr_data,
    input  rd_fifo_rd_en, rd_valid,
    input  sdram_wr_ack, sdram_rd_ack,
    input  sdram_data_out,
    output wr_fifo_full, rd_fifo_rd_data,
    output rd_fifo_empty,
    output sdram_wr_req, sdram_wr_addr,
    output wr_burst_len, sdram_data_in,
    output sdram_rd_req, sdram_rd_addr,
    output rd_burst_len
  );

  modport slave (
    output wr_fifo_wr_en, wr_fifo_wr_data,
    output rd_fifo_rd_en, rd_valid,
    output sdram_wr_ack, sdram_rd_ack,
    output sdram_data_out,
    input  wr_fifo_full, rd_fifo_rd_data,
    input  rd_fifo_empty,
    input  sdram_wr_req, sdram_wr_addr,
    input  wr_burst_len, sdram_data_in,
    input  sdram_rd_req, sdram_rd_addr,
    input  rd_burst_len
  );
endinterface

// File: rtl/sdram_port_ctrl.sv
// sdram_port_ctrl: user-side burst initiator with write and read FIFOs.
// Define SDRAM_PORT_RR_EN for round-robin write/read arbitration.
module sdram_port_ctrl #(
  parameter int          FIFO_AW   = 9,
  parameter logic [8:0]  BURST_LEN = 9'd256,
  parameter logic [20:0] WR_BASE   = 21'd0,
  parameter logic [20:0] WR_END    = 21'd4096,
  parameter logic [20:0] RD_BASE   = 21'd0,
  parameter logic [20:0] RD_END    = 21'd4096
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  sdram_port_ctrl_if.master bus
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] LP_DEPTH =
    (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LP_BL =
    (FIFO_AW + 1)'(BURST_LEN);
  localparam logic [FIFO_AW:0] LP_C1 = 1;
  localparam logic [FIFO_AW-1:0] LP_P1 = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_BURST,
    S_RD_REQ,
    S_RD_BURST
  } state_t;

  logic [31:0]        r_wf_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wf_wp, r_wf_rp;
  logic [FIFO_AW:0]   r_wf_cnt;
  logic [31:0]        r_wf_last;
  logic w_wf_push, w_wf_pop;
  logic w_wf_full, w_wf_empty;

  assign w_wf_full  = r_wf_cnt == LP_DEPTH;
  assign w_wf_empty = r_wf_cnt == '0;
  assign w_wf_push  = bus.wr_fifo_wr_en && !w_wf_full;
  assign w_wf_pop   = bus.sdram_wr_ack && !w_wf_empty;

  always_ff @(posedge sys_clk) begin
    if (w_wf_push)
      r_wf_mem[r_wf_wp] <= bus.wr_fifo_wr_data;
  end

  // r_wf_last keeps the head stable once the FIFO drains
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wf_wp   <= '0;
      r_wf_rp   <= '0;
      r_wf_cnt  <= '0;
      r_wf_last <= '0;
    end else begin
      if (w_wf_push)
        r_wf_wp <= r_wf_wp + LP_P1;
      if (w_wf_pop) begin
        r_wf_rp   <= r_wf_rp + LP_P1;
        r_wf_last <= r_wf_mem[r_wf_rp];
      end
      r_wf_cnt <= r_wf_cnt
        + (w_wf_push ? LP_C1 : '0)
        - (w_wf_pop ? LP_C1 : '0);
    end
  end

  assign bus.wr_fifo_full  = w_wf_full;
  assign bus.sdram_data_in =
    w_wf_empty ? r_wf_last : r_wf_mem[r_wf_rp];

  logic [31:0]        r_rf_mem [DEPTH];
  logic [FIFO_AW-1:0] r_rf_wp, r_rf_rp;
  logic [FIFO_AW:0]   r_rf_cnt;
  logic [31:0]        r_rf_last;
  logic w_rf_push, w_rf_pop;
  logic w_rf_full, w_rf_empty;

  assign w_rf_full  = r_rf_cnt == LP_DEPTH;
  assign w_rf_empty = r_rf_cnt == '0;
  assign w_rf_push  = bus.sdram_rd_ack && !w_rf_full;
  assign w_rf_pop   = bus.rd_fifo_rd_en && !w_rf_empty;

  always_ff @(posedge sys_clk) begin
    if (w_rf_push)
      r_rf_mem[r_rf_wp] <= bus.sdram_data_out;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_rf_wp   <= '0;
      r_rf_rp   <= '0;
      r_rf_cnt  <= '0;
      r_rf_last <= '0;
    end else begin
      if (w_rf_push)
        r_rf_wp <= r_rf_wp + LP_P1;
      if (w_rf_pop) begin
        r_rf_rp   <= r_rf_rp + LP_P1;
        r_rf_last <= r_rf_mem[r_rf_rp];
      end
      r_rf_cnt <= r_rf_cnt
        + (w_rf_push ? LP_C1 : '0)
        - (w_rf_pop ? LP_C1 : '0);
    end
  end

  assign bus.rd_fifo_empty   = w_rf_empty;
  assign bus.rd_fifo_rd_data =
    w_rf_empty ? r_rf_last : r_rf_mem[r_rf_rp];

  state_t r_state, w_state_nx;
  logic r_wr_ack_d, r_rd_ack_d;
  logic [20:0] r_wr_addr, r_rd_addr;
  logic w_wr_elig, w_rd_elig;
  logic w_grant_wr, w_grant_rd;
  logic w_wr_req, w_rd_req;
  logic w_wr_done, w_rd_done;
  logic [21:0] w_wr_sum, w_rd_sum;

  assign w_wr_elig = init_end
    && (r_wf_cnt >= LP_BL);
  assign w_rd_elig = init_end && bus.rd_valid
    && ((LP_DEPTH - r_rf_cnt) >= LP_BL);

`ifdef SDRAM_PORT_RR_EN
  // set means the last granted burst was a write
  logic r_last_wr;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      r_last_wr <= 1'b0;
    else if (r_state == S_IDLE) begin
      if (w_grant_wr)
        r_last_wr <= 1'b1;
      else if (w_grant_rd)
        r_last_wr <= 1'b0;
    end
  end

  assign w_grant_wr = w_wr_elig
    && (!w_rd_elig || !r_last_wr);
`else
  assign w_grant_wr = w_wr_elig;
`endif
  assign w_grant_rd = w_rd_elig && !w_grant_wr;

  always_comb begin
    w_state_nx = r_state;
    w_wr_req   = 1'b0;
    w_rd_req   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_wr)
          w_state_nx = S_WR_REQ;
        else if (w_grant_rd)
          w_state_nx = S_RD_REQ;
      end
      S_WR_REQ: begin
        w_wr_req = 1'b1;
        if (bus.sdram_wr_ack)
          w_state_nx = S_WR_BURST;
      end
      S_WR_BURST: begin
        if (r_wr_ack_d && !bus.sdram_wr_ack)
          w_state_nx = S_IDLE;
      end
      S_RD_REQ: begin
        w_rd_req = 1'b1;
        if (bus.sdram_rd_ack)
          w_state_nx = S_RD_BURST;
      end
      S_RD_BURST: begin
        if (r_rd_ack_d && !bus.sdram_rd_ack)
          w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_wr_ack_d <= 1'b0;
      r_rd_ack_d <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_wr_ack_d <= bus.sdram_wr_ack;
      r_rd_ack_d <= bus.sdram_rd_ack;
    end
  end

  assign w_wr_done = (r_state == S_WR_BURST)
    && r_wr_ack_d && !bus.sdram_wr_ack;
  assign w_rd_done = (r_state == S_RD_BURST)
    && r_rd_ack_d && !bus.sdram_rd_ack;
  // one spare bit so a region ending near 2**21 cannot overflow
  assign w_wr_sum = {1'b0, r_wr_addr}
    + {13'd0, BURST_LEN};
  assign w_rd_sum = {1'b0, r_rd_addr}
    + {13'd0, BURST_LEN};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_addr <= WR_BASE;
      r_rd_addr <= RD_BASE;
    end else begin
      if (w_wr_done)
        r_wr_addr <= (w_wr_sum >= {1'b0, WR_END})
          ? WR_BASE : w_wr_sum[20:0];
      if (w_rd_done)
        r_rd_addr <= (w_rd_sum >= {1'b0, RD_END})
          ? RD_BASE : w_rd_sum[20:0];
    end
  end

  assign bus.sdram_wr_req  = w_wr_req;
  assign bus.sdram_rd_req  = w_rd_req;
  assign bus.sdram_wr_addr = r_wr_addr;
  assign bus.sdram_rd_addr = r_rd_addr;
  assign bus.wr_burst_len  = BURST_LEN;
  assign bus.rd_burst_len  = BURST_LEN;
endmodule
